// File: rtl/sched_pkg.sv
// sched_pkg: shared definitions for the matmul tile scheduler.
//   sched_state_t   - scheduler FSM state encoding
//   SCHED_DATA_W    - default systolic-array result element width
//   SCHED_TILE      - default systolic-array edge (TILE x TILE block)
//   SCHED_ACC_W     - default accumulator element width
package sched_pkg;

  localparam int SCHED_DATA_W = 16;
  localparam int SCHED_TILE   = 2;
  localparam int SCHED_ACC_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_ACCUM = 3'd4,
    S_EMIT  = 3'd5,
    S_DONE  = 3'd6
  } sched_state_t;

endpackage

// File: rtl/tile_accumulator.sv
// tile_accumulator: per-element clear/accumulate register bank for one
// TILE x TILE output block.
//   clk, rst   - clock, synchronous active-high reset (clears every element)
//   acc_en     - update the bank this cycle
//   acc_first  - first K step: start from zero instead of the held value
//   sa_result  - flattened row-major array result, element e at [e*DATA_W +: DATA_W]
//   acc        - flattened accumulator, element e at [e*ACC_W +: ACC_W]
module tile_accumulator
  import sched_pkg::*;
#(
  parameter int TILE   = SCHED_TILE,
  parameter int DATA_W = SCHED_DATA_W,
  parameter int ACC_W  = SCHED_ACC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        acc_en,
  input  logic                        acc_first,
  input  logic [TILE*TILE*DATA_W-1:0] sa_result,
  output logic [TILE*TILE*ACC_W-1:0]  acc
);

  localparam int ELEMS = TILE * TILE;

  logic [ACC_W-1:0] acc_q [ELEMS];

  for (genvar e = 0; e < ELEMS; e++) begin : g_elem
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] base;

    // zero-extend the array element; the sum wraps modulo 2^ACC_W
    assign addend = ACC_W'(sa_result[e*DATA_W +: DATA_W]);
    assign base   = acc_first ? '0 : acc_q[e];

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q[e] <= '0;
      end else if (acc_en) begin
        acc_q[e] <= base + addend;
      end
    end

    assign acc[e*ACC_W +: ACC_W] = acc_q[e];
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: walks an M x N x K tile space (m outer, n middle,
// k inner), fetching operand tiles, running the systolic array per k step,
// accumulating the block result and streaming each finished output tile.
//   clk, rst                  - clock, synchronous active-high reset
//   cmd_valid/cmd_ready       - command handshake; cmd_m/n/k = tile counts
//   fetch_req/fetch_ack       - tile fetch handshake; fetch_m/n/k = tile indices
//   sa_load/sa_start/sa_done  - systolic array control; sa_result = block result
//   out_valid/out_ready       - output tile stream; out_data, out_m, out_n
//   cmd_done                  - one-cycle pulse at command completion
//   err                       - sticky RUN watchdog error
// Build option: define SCHED_TIMEOUT_EN to enable the RUN watchdog
// (TIMEOUT_CYC cycles); otherwise RUN waits forever and err is tied low.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// FETCH | fetch_req high until fetch_ack
// LOAD  | one-cycle sa_load pulse
// RUN   | sa_start high until sa_done (or watchdog expiry)
// ACCUM | fold sa_result into the accumulator, pick next k or emit
// EMIT  | out_valid high until out_ready, then next (m,n) or finish
// DONE  | one-cycle cmd_done pulse
module matmul_tile_scheduler
  import sched_pkg::*;
#(
  parameter int DATA_W      = SCHED_DATA_W,
  parameter int TILE        = SCHED_TILE,
  parameter int CNT_W       = 8,
  parameter int ACC_W       = SCHED_ACC_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [CNT_W-1:0]            cmd_m,
  input  logic [CNT_W-1:0]            cmd_n,
  input  logic [CNT_W-1:0]            cmd_k,
  output logic                        fetch_req,
  input  logic                        fetch_ack,
  output logic [CNT_W-1:0]            fetch_m,
  output logic [CNT_W-1:0]            fetch_n,
  output logic [CNT_W-1:0]            fetch_k,
  output logic                        sa_load,
  output logic                        sa_start,
  input  logic                        sa_done,
  input  logic [TILE*TILE*DATA_W-1:0] sa_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TILE*TILE*ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]            out_m,
  output logic [CNT_W-1:0]            out_n,
  output logic                        cmd_done,
  output logic                        err
);

  if (ACC_W < DATA_W) begin : g_bad_acc_w
    $error("ACC_W must be at least DATA_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  sched_state_t state_q, state_d;

  logic [CNT_W-1:0] lat_m, lat_n, lat_k;
  logic [CNT_W-1:0] m_q, n_q, k_q;
  logic             k_last, n_last, m_last;
  logic             cmd_zero;
  logic             wd_expired;

  assign k_last   = (k_q == lat_k - CNT_W'(1));
  assign n_last   = (n_q == lat_n - CNT_W'(1));
  assign m_last   = (m_q == lat_m - CNT_W'(1));
  assign cmd_zero = (cmd_m == '0) || (cmd_n == '0) || (cmd_k == '0);

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // down-counter armed in LOAD; terminal count reached on the
  // TIMEOUT_CYC-th RUN cycle
  assign wd_expired = (state_q == S_RUN) && !sa_done && (wd_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_LOAD) begin
        wd_q <= WD_W'(TIMEOUT_CYC - 1);
      end else if (state_q == S_RUN && wd_q != '0) begin
        wd_q <= wd_q - WD_W'(1);
      end
      if (wd_expired) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    fetch_req = 1'b0;
    sa_load   = 1'b0;
    sa_start  = 1'b0;
    out_valid = 1'b0;
    cmd_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = cmd_zero ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sa_load = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        sa_start = 1'b1;
        if (sa_done) begin
          state_d = S_ACCUM;
        end else if (wd_expired) begin
          state_d = S_DONE;
        end
      end
      S_ACCUM: begin
        state_d = k_last ? S_EMIT : S_FETCH;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = (n_last && m_last) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        cmd_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_m <= '0;
      lat_n <= '0;
      lat_k <= '0;
      m_q   <= '0;
      n_q   <= '0;
      k_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            lat_m <= cmd_m;
            lat_n <= cmd_n;
            lat_k <= cmd_k;
            m_q   <= '0;
            n_q   <= '0;
            k_q   <= '0;
          end
        end
        S_ACCUM: begin
          if (!k_last) begin
            k_q <= k_q + CNT_W'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            k_q <= '0;
            if (n_last) begin
              n_q <= '0;
              // after the final tile the indices fall back to zero
              m_q <= m_last ? '0 : m_q + CNT_W'(1);
            end else begin
              n_q <= n_q + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fetch_m = m_q;
  assign fetch_n = n_q;
  assign fetch_k = k_q;
  assign out_m   = m_q;
  assign out_n   = n_q;

  tile_accumulator #(
    .TILE   (TILE),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .acc_en    (state_q == S_ACCUM),
    .acc_first (k_q == '0),
    .sa_result (sa_result),
    .acc       (out_data)
  );

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb_matmul_tile_scheduler: directed and randomized command sequences with
// the bench acting as fetch unit, systolic array and output sink. Expected
// output tiles are element-wise sums over k of the results the bench fed in.
module tb_matmul_tile_scheduler;

  localparam int DW = 16;
  localparam int T  = 2;
  localparam int CW = 8;
  localparam int AW = 32;
  localparam int NE = T * T;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CW-1:0]     cmd_m, cmd_n, cmd_k;
  logic              fetch_req;
  logic              fetch_ack;
  logic [CW-1:0]     fetch_m, fetch_n, fetch_k;
  logic              sa_load, sa_start, sa_done;
  logic [NE*DW-1:0]  sa_result;
  logic              out_valid, out_ready;
  logic [NE*AW-1:0]  out_data;
  logic [CW-1:0]     out_m, out_n;
  logic              cmd_done;
  logic              err;

  int total = 0;
  int bad   = 0;

  int n_fetch = 0, n_load = 0, n_run = 0, n_out = 0;
  logic fr_d = 1'b0, ss_d = 1'b0, ov_d = 1'b0;

  always #5 clk = ~clk;

  matmul_tile_scheduler #(
    .DATA_W      (DW),
    .TILE        (T),
    .CNT_W       (CW),
    .ACC_W       (AW),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_m     (cmd_m),
    .cmd_n     (cmd_n),
    .cmd_k     (cmd_k),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .fetch_m   (fetch_m),
    .fetch_n   (fetch_n),
    .fetch_k   (fetch_k),
    .sa_load   (sa_load),
    .sa_start  (sa_start),
    .sa_done   (sa_done),
    .sa_result (sa_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_m     (out_m),
    .out_n     (out_n),
    .cmd_done  (cmd_done),
    .err       (err)
  );

  // phase counters from DUT outputs only (entries into FETCH/RUN/EMIT, LOAD cycles)
  always @(negedge clk) begin
    if (fetch_req && !fr_d) n_fetch <= n_fetch + 1;
    if (sa_load)            n_load  <= n_load + 1;
    if (sa_start && !ss_d)  n_run   <= n_run + 1;
    if (out_valid && !ov_d) n_out   <= n_out + 1;
    fr_d <= fetch_req;
    ss_d <= sa_start;
    ov_d <= out_valid;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // mode 0: random results, 1: element e -> e+1, 2: every element k+1
  task automatic run_cmd(input int cm, input int cn, input int ck, input int mode, input bit stall);
    logic [DW-1:0]     res [0:7][0:NE-1];
    logic [NE*AW-1:0]  exp_v;
    logic [AW-1:0]     s;
    int f0, l0, r0, o0, cyc;
    bit last;
    f0 = n_fetch; l0 = n_load; r0 = n_run; o0 = n_out;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_m = CW'(cm); cmd_n = CW'(cn); cmd_k = CW'(ck);
    tick();
    cmd_valid = 1'b0;
    for (int mi = 0; mi < cm; mi++) begin
      for (int ni = 0; ni < cn; ni++) begin
        for (int ki = 0; ki < ck; ki++) begin
          cyc = 0;
          while (!fetch_req && cyc < 100) begin tick(); cyc++; end
          check("fetch_req", fetch_req, 1);
          check("fetch_idx", {fetch_m, fetch_n, fetch_k}, {CW'(mi), CW'(ni), CW'(ki)});
          check("fetch_ready_low", cmd_ready, 0);
          repeat ($urandom_range(0, 2)) begin
            tick();
            check("fetch_hold", fetch_req, 1);
          end
          fetch_ack = 1'b1;
          tick();
          fetch_ack = 1'b0;
          check("load_phase", {fetch_req, sa_load, sa_start}, 3'b010);
          tick();
          check("run_phase", {sa_load, sa_start}, 2'b01);
          repeat ($urandom_range(0, 3)) begin
            tick();
            check("run_hold", sa_start, 1);
          end
          for (int e = 0; e < NE; e++) begin
            if (mode == 1)      res[ki][e] = DW'(e + 1);
            else if (mode == 2) res[ki][e] = DW'(ki + 1);
            else                res[ki][e] = DW'($urandom);
            sa_result[e*DW +: DW] = res[ki][e];
          end
          sa_done = 1'b1;
          tick();
          sa_done = 1'b0;
          check("run_drop", sa_start, 0);
          tick();
          sa_result = {$urandom, $urandom};
        end
        exp_v = '0;
        for (int e = 0; e < NE; e++) begin
          s = '0;
          for (int ki = 0; ki < ck; ki++) s = s + AW'(res[ki][e]);
          exp_v[e*AW +: AW] = s;
        end
        cyc = 0;
        while (!out_valid && cyc < 100) begin tick(); cyc++; end
        check("out_valid", out_valid, 1);
        check("out_data", out_data, exp_v);
        check("out_coord", {out_m, out_n}, {CW'(mi), CW'(ni)});
        if (stall) begin
          sa_done = 1'b1;
          repeat (10) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, exp_v);
            check("stall_coord", {out_m, out_n}, {CW'(mi), CW'(ni)});
            check("stall_no_fetch", fetch_req, 0);
          end
          sa_done = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        last = (mi == cm - 1) && (ni == cn - 1);
        check("cmd_done_after_out", cmd_done, last);
      end
    end
    check("done_ready_low", cmd_ready, 0);
    tick();
    check("done_one_cycle", cmd_done, 0);
    check("ready_after_done", cmd_ready, 1);
    tick();
    check("cnt_fetch", n_fetch - f0, cm * cn * ck);
    check("cnt_load", n_load - l0, cm * cn * ck);
    check("cnt_run", n_run - r0, cm * cn * ck);
    check("cnt_out", n_out - o0, cm * cn);
  endtask

  task automatic zero_cmd(input int cm, input int cn, input int ck);
    int f0, o0;
    f0 = n_fetch; o0 = n_out;
    cmd_valid = 1'b1;
    cmd_m = CW'(cm); cmd_n = CW'(cn); cmd_k = CW'(ck);
    tick();
    cmd_valid = 1'b0;
    check("zero_done", {cmd_done, cmd_ready, fetch_req, out_valid}, 4'b1000);
    tick();
    check("zero_idle", {cmd_done, cmd_ready}, 2'b01);
    tick();
    check("zero_no_fetch", n_fetch - f0, 0);
    check("zero_no_out", n_out - o0, 0);
  endtask

  // bring a 1/1/1 command up to its first RUN cycle
  task automatic to_run();
    int cyc;
    cmd_valid = 1'b1;
    cmd_m = 1; cmd_n = 1; cmd_k = 1;
    tick();
    cmd_valid = 1'b0;
    cyc = 0;
    while (!fetch_req && cyc < 100) begin tick(); cyc++; end
    check("prerun_fetch", fetch_req, 1);
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    tick();
    check("prerun_run", sa_start, 1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_m = '0; cmd_n = '0; cmd_k = '0;
    fetch_ack = 1'b0; sa_done = 1'b0; sa_result = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_ctrl", {fetch_req, sa_load, sa_start, out_valid, cmd_done, err}, 6'b0);
    check("rst_data", out_data, 0);
    check("rst_idx", {fetch_m, fetch_n, fetch_k, out_m, out_n}, 0);
    rst = 1'b0;
    tick();

    run_cmd(1, 1, 1, 1, 1'b0);
    run_cmd(1, 1, 3, 2, 1'b0);
    run_cmd(2, 2, 1, 0, 1'b0);
    run_cmd(1, 2, 2, 0, 1'b1);
    zero_cmd(0, 3, 1);
    zero_cmd(2, 2, 0);
    repeat (4) begin
      run_cmd($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 4),
              0, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of RUN; acc holds the previous tile's nonzero sum
    to_run();
    rst = 1'b1;
    tick();
    check("midrun_ready", cmd_ready, 1);
    check("midrun_ctrl", {fetch_req, sa_load, sa_start, out_valid, cmd_done, err}, 6'b0);
    check("midrun_acc_clear", out_data, 0);
    check("midrun_idx", {fetch_m, fetch_n, fetch_k}, 0);
    rst = 1'b0;
    tick();

    to_run();
`ifdef SCHED_TIMEOUT_EN
    cyc = 0;
    while (sa_start && cyc < 200) begin cyc++; tick(); end
    check("wd_run_cycles", cyc, 64);
    check("wd_err_done", {err, cmd_done, sa_start}, 3'b110);
    tick();
    check("wd_idle_sticky", {cmd_ready, err, cmd_done}, 3'b110);
    tick();
    check("wd_err_holds", err, 1);
`else
    repeat (100) tick();
    check("nowd_still_run", sa_start, 1);
    check("nowd_err", err, 0);
`endif
    rst = 1'b1;
    tick();
    check("final_rst_err", err, 0);
    check("final_rst_ready", cmd_ready, 1);
    rst = 1'b0;
    tick();
    run_cmd(2, 1, 2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_tile_scheduler.md
MATMUL_TILE_SCHEDULER -- requirements
Module: matmul_tile_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the element width of the systolic-array result.
REQ-002 SHALL have parameter TILE, default 2, the systolic-array edge (TILE x TILE block).
REQ-003 SHALL have parameter CNT_W, default 8, the width of the tile-count fields.
REQ-004 SHALL have parameter ACC_W, default 32, the accumulator element width (ACC_W >= DATA_W).
REQ-005 SHALL have parameter TIMEOUT_CYC, default 64, the RUN watchdog limit (used only under REQ-030).
REQ-006 SHALL have port clk, input, 1, the clock; reset rst, synchronous, active-high.
REQ-007 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-008 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), the command handshake.
REQ-009 SHALL have ports cmd_m, cmd_n, cmd_k, each input, CNT_W, the tile counts along M, N and K.
REQ-010 SHALL have ports fetch_req (output, 1) and fetch_ack (input, 1), the tile-fetch handshake.
REQ-011 SHALL have ports fetch_m, fetch_n, fetch_k, each output, CNT_W, the current tile indices.
REQ-012 SHALL have ports sa_load (output, 1), sa_start (output, 1) and sa_done (input, 1), the array control.
REQ-013 SHALL have port sa_result, input, TILE*TILE*DATA_W, the flattened row-major block result.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, TILE*TILE*ACC_W), the output-tile stream.
REQ-015 SHALL have ports out_m and out_n, each output, CNT_W, the coordinates of the output tile.
REQ-016 SHALL have ports cmd_done (output, 1, one-cycle pulse) and err (output, 1, sticky error flag).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, LOAD, RUN, ACCUM, EMIT and DONE.
REQ-018 SHALL assert cmd_ready only in IDLE, and SHALL latch cmd_m, cmd_n and cmd_k on cmd_valid&&cmd_ready.
REQ-019 SHALL, on accept with any count zero, go to DONE, pulse cmd_done, and emit no tiles.
REQ-020 SHALL iterate tiles with m outermost, n middle and k innermost, all indices starting at 0.
REQ-021 SHALL hold fetch_req high in FETCH until fetch_ack is sampled (same-cycle ack allowed), then go to LOAD.
REQ-022 SHALL assert sa_load for exactly one cycle in LOAD, then go to RUN.
REQ-023 SHALL hold sa_start high in RUN until sa_done is sampled high, deasserting it the following cycle, and SHALL ignore sa_done in every other state.
REQ-024 SHALL, in ACCUM (one cycle), set each acc element to (k==0 ? 0 : acc) plus the zero-extended sa_result element, with the sum taken modulo 2^ACC_W.
REQ-025 SHALL go from ACCUM to FETCH with k+1 when k < cmd_k-1, and otherwise to EMIT.
REQ-026 SHALL, in EMIT, hold out_valid with stable out_data, out_m and out_n until out_ready, then advance n (wrap to 0 and increment m), or go to DONE after the last tile.
REQ-027 SHALL, in DONE, pulse cmd_done for one cycle and return to IDLE.
REQ-028 SHALL take exactly cmd_m*cmd_n output handshakes per command; a new command SHALL be accepted no earlier than the cycle after cmd_done.

Reset
REQ-029 SHALL on rst (including mid-command) force IDLE, set cmd_ready=1, set every other output to 0 (including err), and clear acc and the counters.

Configuration
REQ-030 SHALL, when SCHED_TIMEOUT_EN is defined, count RUN cycles and, at TIMEOUT_CYC without sa_done, set err, drop sa_start and go to DONE.
REQ-031 SHALL, without SCHED_TIMEOUT_EN, contain no watchdog logic, wait indefinitely in RUN, and tie err to 0.

Structure
REQ-032 SHALL take the state enum and the DATA_W, TILE and ACC_W defaults from shared package sched_pkg.
REQ-033 SHALL place the clear/accumulate datapath in sub-module tile_accumulator, with the FSM and counters in the top module.

Verification
REQ-034 SHALL cover cmd 1/1/1 with sa_result={1,2,3,4}: out_data={1,2,3,4}, out_m=out_n=0, cmd_done one cycle after out_ready.
REQ-035 SHALL cover cmd 1/1/3 with results {1,1,1,1}, {2,2,2,2} and {3,3,3,3}: one output {6,6,6,6}, and three each of fetch, load and RUN phases.
REQ-036 SHALL cover cmd 2/2/1: outputs at (m,n) = (0,0),(0,1),(1,0),(1,1), with fetch_k always 0.
REQ-037 SHALL cover out_ready low for 10 cycles: out_valid and out_data stable, no fetch_req issued during the stall.
REQ-038 SHALL cover cmd 0/3/1: cmd_done pulses with no fetch_req and no out_valid.
REQ-039 SHALL cover rst asserted mid-RUN: next cycle IDLE, sa_start=0, cmd_ready=1; with SCHED_TIMEOUT_EN and sa_done never asserted, err=1 after 64 RUN cycles, then cmd_done.
